ram_io_responder: RTL

- Responder (target) end of the byte-serial RAM bus that memory_controller drives.
- Services one byte per cycle on `mem_ram_addr`, `mem_ram_data` and `mem_ram_wr`, and returns read data on `ram_data`.
- Backs a byte-addressed RAM array and decodes an I/O window.
- The I/O window feeds a TX byte FIFO (program output), drains an RX byte FIFO (program input), and raises a finish flag.
- Sits at top level between the CPU and the simulation/host harness.

---
 rtl/ram_io_responder_pkg.sv | 22 ++
 rtl/ram_io_responder_byte_fifo.sv | 46 ++++
 rtl/ram_io_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants and access decoding for the byte-serial RAM/I-O responder.
package ram_io_responder_pkg;

   localparam int unsigned XLEN        = 32;
   localparam logic [31:0] IO_BASE     = 32'h30000;
   localparam logic [2:0]  IO_DATA_OFS = 3'd0;
   localparam logic [2:0]  IO_CTRL_OFS = 3'd4;
   localparam logic [1:0]  IO_SEL_BITS = IO_BASE[17:16];

   typedef enum logic [1:0] {
      ACC_RAM_RD,
      ACC_RAM_WR,
      ACC_IO_RD,
      ACC_IO_WR
   } access_e;

   function automatic access_e classify(input logic [1:0] sel, input logic wr);
      if (sel == IO_SEL_BITS) return wr ? ACC_IO_WR : ACC_IO_RD;
      return wr ? ACC_RAM_WR : ACC_RAM_RD;
   endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; push while full is accepted only alongside a pop.
module byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [7:0]             i_data,
   input  logic                   i_pop,
   output logic [7:0]             o_data,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]  r_buf [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_full;
   logic        w_empty;
   logic        w_pop_ok;
   logic        w_push_ok;

   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_pop_ok  = i_pop && !w_empty;
   assign w_push_ok = i_push && (!w_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_buf[r_wr_ptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign o_data  = r_buf[r_rd_ptr[AW-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ram_io_responder.sv
// Target end of the byte-serial RAM bus: byte RAM plus TX/RX FIFO and finish I/O window.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter              INIT_FILE  = "test.data"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic [XLEN-1:0] mem_ram_addr,
  input  logic [7:0]      mem_ram_data,
  input  logic            mem_ram_wr,
  output logic [7:0]      ram_data,
  output logic            io_buffer_full,
  output logic [7:0]      io_tx_data,
  output logic            io_tx_valid,
  input  logic            io_tx_ready,
  input  logic [7:0]      io_rx_data,
  input  logic            io_rx_valid,
  output logic            io_rx_ready,
  output logic            sim_finish
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            r_mem [1 << ADDR_WIDTH];
  logic [7:0]            r_ram_data;
  logic                  r_finish;
  logic                  r_buf_full;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_ofs;
  access_e               w_acc;
  logic                  w_unused_addr;
  logic                  w_unused_init;

  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_tx_push_ok;
  logic [CW-1:0]         w_tx_cnt;
  logic [CW-1:0]         w_tx_cnt_nxt;
  logic                  w_rx_push;
  logic                  w_rx_pop;
  logic                  w_rx_empty;
  logic [CW-1:0]         w_rx_cnt;
  logic [7:0]            w_rx_head;

  assign w_unused_init = ^INIT_FILE;

  assign w_addr        = mem_ram_addr[ADDR_WIDTH-1:0];
  assign w_ofs         = mem_ram_addr[2:0];
  assign w_acc         = classify(mem_ram_addr[17:16], mem_ram_wr);
  assign w_unused_addr = ^mem_ram_addr[XLEN-1:18];

  assign w_tx_push    = rdy && (w_acc == ACC_IO_WR) && (w_ofs == IO_DATA_OFS);
  assign w_tx_pop     = rdy && io_tx_valid && io_tx_ready;
  assign w_rx_push    = rdy && io_rx_valid && io_rx_ready;
  assign w_rx_pop     = rdy && (w_acc == ACC_IO_RD) && (w_ofs == IO_DATA_OFS);

  assign w_tx_full    = (w_tx_cnt == CW'(FIFO_DEPTH));
  assign w_tx_empty   = (w_tx_cnt == '0);
  assign w_rx_empty   = (w_rx_cnt == '0);

  // Mirrors the FIFO's accept rule so the almost-full flag tracks the post-edge count.
  assign w_tx_push_ok = w_tx_push && (!w_tx_full || w_tx_pop);
  assign w_tx_cnt_nxt = w_tx_cnt + CW'(w_tx_push_ok) - CW'(w_tx_pop);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_tx_push),
    .i_data  (mem_ram_data),
    .i_pop   (w_tx_pop),
    .o_data  (io_tx_data),
    .o_count (w_tx_cnt)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_rx_push),
    .i_data  (io_rx_data),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_count (w_rx_cnt)
  );

  always_ff @(posedge clk) begin
    if (rdy && (w_acc == ACC_RAM_WR)) r_mem[w_addr] <= mem_ram_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ram_data <= '0;
      r_finish   <= 1'b0;
      r_buf_full <= 1'b0;
    end else if (rdy) begin
      r_buf_full <= (w_tx_cnt_nxt >= CW'(FIFO_DEPTH - 2));
      case (w_acc)
        ACC_RAM_RD: r_ram_data <= r_mem[w_addr];
        ACC_IO_RD: begin
          // An empty RX read returns 0 even if the host pushes on this same edge.
          if (w_ofs == IO_DATA_OFS)
            r_ram_data <= w_rx_empty ? '0 : w_rx_head;
          else if (w_ofs == IO_CTRL_OFS)
            r_ram_data <= {6'b0, !w_rx_empty, w_tx_full};
          else
            r_ram_data <= '0;
        end
        ACC_IO_WR: begin
          r_ram_data <= '0;
          if (w_ofs == IO_CTRL_OFS) r_finish <= 1'b1;
        end
        default: r_ram_data <= '0;
      endcase
    end
  end

  assign ram_data       = r_ram_data;
  assign sim_finish     = r_finish;
  assign io_buffer_full = r_buf_full;
  assign io_tx_valid    = !w_tx_empty;
  assign io_rx_ready    = (w_rx_cnt != CW'(FIFO_DEPTH));

endmodule
